// File: rtl/data_stream_mux_tdm.sv
// rtl/data_stream_mux_tdm.sv - symbol-framed TDM multiplexer of NUM_CH streams onto one output.
// Define DSMUX_OVERRUN_CNT_EN to build the saturating overrun counter; otherwise overrun_cnt is tied to 0.
module data_stream_mux_tdm #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         symbol_stb,
  input  logic [$clog2(NUM_CH+1)-1:0]  mode,
  input  logic [CNT_W-1:0]             slot_cycles,
  input  logic [NUM_CH*DATA_W-1:0]     ds_in,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  output logic                         cfg_err,
  output logic [7:0]                   overrun_cnt
);

  localparam int MODE_W = $clog2(NUM_CH+1);
  localparam int LANE_W = $clog2(NUM_CH);
  localparam logic [MODE_W-1:0] MAX_M = MODE_W'(NUM_CH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, nxt_state;
  logic [DATA_W-1:0] shadow     [NUM_CH];
  logic [DATA_W-1:0] nxt_shadow [NUM_CH];
  logic [MODE_W-1:0] m_lat, nxt_m_lat;
  logic [CNT_W-1:0]  s_lat, nxt_s_lat;
  logic [LANE_W-1:0] lane, nxt_lane;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic [DATA_W-1:0] nxt_out_data;
  logic              nxt_out_valid;
  logic [LANE_W-1:0] nxt_out_ch;
  logic              nxt_cfg_err;
  logic [MODE_W-1:0] m_in;
  logic              slot_end;
  logic              lane_last;

  assign m_in      = (mode > MAX_M) ? MAX_M : mode;
  assign slot_end  = (cnt == s_lat - CNT_W'(1));
  assign lane_last = (MODE_W'(lane) == m_lat - MODE_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      m_lat     <= '0;
      s_lat     <= '0;
      lane      <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      cfg_err   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else begin
      state     <= nxt_state;
      m_lat     <= nxt_m_lat;
      s_lat     <= nxt_s_lat;
      lane      <= nxt_lane;
      cnt       <= nxt_cnt;
      out_data  <= nxt_out_data;
      out_valid <= nxt_out_valid;
      out_ch    <= nxt_out_ch;
      cfg_err   <= nxt_cfg_err;
      shadow    <= nxt_shadow;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_shadow    = shadow;
    nxt_m_lat     = m_lat;
    nxt_s_lat     = s_lat;
    nxt_lane      = lane;
    nxt_cnt       = cnt;
    nxt_out_data  = out_data;
    nxt_out_valid = out_valid;
    nxt_out_ch    = out_ch;
    nxt_cfg_err   = cfg_err;

    if (symbol_stb) begin
      // A strobe always (re)starts a frame from freshly captured lanes and config.
      for (int k = 0; k < NUM_CH; k++) nxt_shadow[k] = ds_in[k*DATA_W +: DATA_W];
      nxt_m_lat  = m_in;
      nxt_s_lat  = (slot_cycles == '0) ? CNT_W'(1) : slot_cycles;
      nxt_lane   = '0;
      nxt_cnt    = '0;
      nxt_out_ch = '0;
      if (mode > MAX_M) nxt_cfg_err = 1'b1;
      if (m_in != '0) begin
        nxt_state     = RUN;
        nxt_out_valid = 1'b1;
        nxt_out_data  = ds_in[DATA_W-1:0];
      end else begin
        nxt_state     = IDLE;
        nxt_out_valid = 1'b0;
        nxt_out_data  = '0;
      end
    end else if (state == RUN) begin
      if (slot_end) begin
        nxt_cnt = '0;
        if (lane_last) begin
          nxt_state     = IDLE;
          nxt_lane      = '0;
          nxt_out_valid = 1'b0;
          nxt_out_data  = '0;
          nxt_out_ch    = '0;
        end else begin
          nxt_lane     = lane + LANE_W'(1);
          nxt_out_data = shadow[nxt_lane];
          nxt_out_ch   = nxt_lane;
        end
      end else begin
        nxt_cnt = cnt + CNT_W'(1);
      end
    end
  end

`ifdef DSMUX_OVERRUN_CNT_EN
  logic       overrun;
  logic [7:0] ovr_q;

  // A strobe landing on the frame's final slot cycle is a clean hand-off, not an overrun.
  assign overrun = symbol_stb && (state == RUN) && !(lane_last && slot_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q <= '0;
    end else if (overrun && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_data_stream_mux_tdm.sv
// tb/tb_data_stream_mux_tdm.sv - scoreboard bench for data_stream_mux_tdm (honours DSMUX_OVERRUN_CNT_EN).
module tb_data_stream_mux_tdm;

`ifdef DSMUX_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        symbol_stb;
  logic [2:0]  mode;
  logic [15:0] slot_cycles;
  logic [31:0] ds [4];
  logic [127:0] ds_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic        cfg_err;
  logic [7:0]  overrun_cnt;

  assign ds_in = {ds[3], ds[2], ds[1], ds[0]};

  data_stream_mux_tdm #(.NUM_CH(4), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .symbol_stb(symbol_stb), .mode(mode),
    .slot_cycles(slot_cycles), .ds_in(ds_in), .out_data(out_data),
    .out_valid(out_valid), .out_ch(out_ch), .cfg_err(cfg_err),
    .overrun_cnt(overrun_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [1:0]  ch;
    logic        cfg;
    logic [7:0]  ovr;
    int          scen;
  } exp_t;

  exp_t plan[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   scen    = 0;
  int   cyc     = 0;
  logic       exp_cfg = 1'b0;
  logic [7:0] exp_ovr = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

  task automatic exp_beats(input logic [31:0] d, input int ch, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.v = 1'b1; e.d = d; e.ch = 2'(ch); e.cfg = exp_cfg; e.ovr = exp_ovr; e.scen = scen;
      plan.push_back(e);
    end
  endtask

  task automatic exp_idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.v = 1'b0; e.d = '0; e.ch = '0; e.cfg = exp_cfg; e.ovr = exp_ovr; e.scen = scen;
      plan.push_back(e);
    end
  endtask

  task automatic drive_cycle(input logic stb);
    @(negedge clk);
    symbol_stb = stb;
    if (plan.size() > 0) begin
      sb.push_back(plan.pop_front());
    end else begin
      n_total++;
      $display("FAIL plan_underrun scen=%0d got=empty want=entry", scen);
    end
  endtask

  task automatic run(input int n, input int period, input int nstb);
    for (int i = 0; i < n; i++) drive_cycle((i % period == 0) && (i / period < nstb));
  endtask

  task automatic check_zero(input string name);
    n_total++;
    if ({out_valid, out_ch, cfg_err, overrun_cnt, out_data} === '0) n_pass++;
    else $display("FAIL %s got v=%0b ch=%0d d=%h cfg=%0b ovr=%0d want all 0",
                  name, out_valid, out_ch, out_data, cfg_err, overrun_cnt);
  endtask

  // Monitor: one expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_total++;
        if ({out_valid, out_ch, out_data} === {e.v, e.ch, e.d}) n_pass++;
        else $display("FAIL stream scen=%0d cyc=%0d got v=%0b ch=%0d d=%h want v=%0b ch=%0d d=%h",
                      e.scen, cyc, out_valid, out_ch, out_data, e.v, e.ch, e.d);
        n_total++;
        if ({cfg_err, overrun_cnt} === {e.cfg, e.ovr}) n_pass++;
        else $display("FAIL status scen=%0d cyc=%0d got cfg=%0b ovr=%0d want cfg=%0b ovr=%0d",
                      e.scen, cyc, cfg_err, overrun_cnt, e.cfg, e.ovr);
      end
    end
  end

  initial begin
    rst = 1'b0; symbol_stb = 1'b0; mode = 3'd1; slot_cycles = 16'd12;
    ds[0] = 32'hA5A5A5A5; ds[1] = 32'h5A5A5A5A; ds[2] = 32'h0F0F0F0F; ds[3] = 32'hF0F0F0F0;
    repeat (3) @(negedge clk);
    check_zero("reset_init");
    rst = 1'b1;

    // Data present and config set, but no strobe yet: nothing may come out.
    scen = 0;
    exp_idle(3);
    run(3, 1, 0);

    // mode=1, S=12, strobe every 12: continuous lane 0, no overrun.
    scen = 1;
    exp_beats(32'hA5A5A5A5, 0, 36);
    exp_idle(2);
    run(36, 12, 3);
    run(2, 1, 0);

    // mode=2, S=6, strobe every 12; inputs change mid-frame without effect.
    scen = 2;
    mode = 3'd2; slot_cycles = 16'd6;
    ds[0] = 32'h11111111; ds[1] = 32'h22222222;
    for (int f = 0; f < 2; f++) begin
      exp_beats(32'h11111111, 0, 6);
      exp_beats(32'h22222222, 1, 6);
    end
    exp_idle(2);
    run(12, 12, 1);
    run(3, 1, 1);
    ds[0] = 32'hBAD00000; ds[1] = 32'hBAD11111; mode = 3'd1; slot_cycles = 16'd3;
    run(9, 1, 0);
    run(2, 1, 0);

    // mode=3, S=4, strobe every 20: 12 valid cycles then 8 idle, twice.
    scen = 3;
    mode = 3'd3; slot_cycles = 16'd4;
    ds[0] = 32'hA0000000; ds[1] = 32'hB1111111; ds[2] = 32'hC2222222; ds[3] = 32'hD3333333;
    for (int f = 0; f < 2; f++) begin
      exp_beats(32'hA0000000, 0, 4);
      exp_beats(32'hB1111111, 1, 4);
      exp_beats(32'hC2222222, 2, 4);
      exp_idle(8);
    end
    run(40, 20, 2);

    // mode=4, S=5, restart after 7 cycles: overrun, new data from lane 0.
    scen = 4;
    mode = 3'd4; slot_cycles = 16'd5;
    ds[0] = 32'h00000010; ds[1] = 32'h00000011; ds[2] = 32'h00000012; ds[3] = 32'h00000013;
    exp_beats(32'h00000010, 0, 5);
    exp_beats(32'h00000011, 1, 2);
    exp_ovr = OVR_EN ? 8'd1 : 8'd0;
    exp_beats(32'h00000020, 0, 5);
    exp_beats(32'h00000021, 1, 5);
    exp_beats(32'h00000022, 2, 5);
    exp_beats(32'h00000023, 3, 5);
    exp_idle(2);
    run(7, 1, 1);
    ds[0] = 32'h00000020; ds[1] = 32'h00000021; ds[2] = 32'h00000022; ds[3] = 32'h00000023;
    run(22, 1, 1);

    // mode=7 clamps to 4 lanes and sets sticky cfg_err; mode=0 stays idle; S=0 acts as 1.
    scen = 5;
    mode = 3'd7; slot_cycles = 16'd2;
    exp_cfg = 1'b1;
    exp_beats(32'h00000020, 0, 2);
    exp_beats(32'h00000021, 1, 2);
    exp_beats(32'h00000022, 2, 2);
    exp_beats(32'h00000023, 3, 2);
    exp_idle(2);
    run(10, 1, 1);
    mode = 3'd0;
    exp_idle(4);
    run(4, 1, 1);
    mode = 3'd2; slot_cycles = 16'd0;
    exp_beats(32'h00000020, 0, 1);
    exp_beats(32'h00000021, 1, 1);
    exp_idle(2);
    run(4, 1, 1);

    // Asynchronous reset during lane 1 clears everything at once.
    scen = 6;
    mode = 3'd4; slot_cycles = 16'd3;
    ds[0] = 32'hCAFE0000; ds[1] = 32'hCAFE0001; ds[2] = 32'hCAFE0002; ds[3] = 32'hCAFE0003;
    exp_beats(32'hCAFE0000, 0, 3);
    exp_beats(32'hCAFE0001, 1, 2);
    run(5, 1, 1);
    @(posedge clk);
    #3;
    symbol_stb = 1'b0;
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (2) @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b1;
    exp_cfg = 1'b0; exp_ovr = 8'd0;
    exp_idle(5);
    run(5, 1, 0);
    mode = 3'd1; slot_cycles = 16'd2;
    exp_beats(32'hCAFE0000, 0, 2);
    exp_idle(2);
    run(4, 1, 1);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #5;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_stream_mux_tdm.md
DATA_STREAM_MUX_TDM -- requirements
Module: data_stream_mux_tdm

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of input data streams (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of each stream in bits.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the slot-length counter.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port symbol_stb, input, 1, a one-cycle pulse in the clk domain marking each symbol boundary.
REQ-007 The block SHALL have port mode, input, $clog2(NUM_CH+1), the number of streams to interleave per symbol (0 = off).
REQ-008 The block SHALL have port slot_cycles, input, CNT_W, the number of clk cycles each stream is driven.
REQ-009 The block SHALL have port ds_in, input, NUM_CH*DATA_W, the flat stream bus; stream k is bits [k*DATA_W +: DATA_W].
REQ-010 The block SHALL have port out_data, output, DATA_W, the multiplexed stream.
REQ-011 The block SHALL have port out_valid, output, 1, high while out_data carries a slot.
REQ-012 The block SHALL have port out_ch, output, $clog2(NUM_CH), the index of the stream on out_data.
REQ-013 The block SHALL have port cfg_err, output, 1, a sticky flag for illegal mode.
REQ-014 The block SHALL have port overrun_cnt, output, 8, the count of symbol boundaries that truncated a frame.

Function
REQ-015 On symbol_stb, the block SHALL capture all ds_in lanes into shadow registers and latch mode and slot_cycles; mid-frame input changes SHALL have no effect.
REQ-016 The FSM SHALL have states IDLE and RUN.
REQ-017 In IDLE, symbol_stb with latched mode != 0 SHALL move to RUN; with mode = 0 it SHALL stay in IDLE.
REQ-018 Latency: if symbol_stb is high in cycle t, out_data SHALL show shadow lane 0 with out_valid=1 and out_ch=0 from cycle t+1.
REQ-019 In RUN, each lane k = 0..M-1 (M = latched mode) SHALL be driven for exactly S consecutive cycles (S = latched slot_cycles), then lane k+1 follows.
REQ-020 After lane M-1 completes its S cycles with no strobe, the FSM SHALL enter IDLE, with out_valid=0, out_data=0 and out_ch=0.
REQ-021 A slot_cycles value of 0 SHALL be treated as S=1.
REQ-022 If mode > NUM_CH, the block SHALL use M=NUM_CH and set cfg_err; cfg_err SHALL clear only on reset.
REQ-023 A symbol_stb while in RUN, before the frame completes, SHALL restart the frame at lane 0 with the newly captured data and config, and SHALL count one overrun.
REQ-024 A symbol_stb in the same cycle as the frame's final slot cycle SHALL NOT count as an overrun; the new frame SHALL start with no idle gap.
REQ-025 The slot counter SHALL be CNT_W bits wide and SHALL never wrap within a slot.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While rst=0, the block SHALL hold state IDLE, and out_data, out_valid, out_ch, cfg_err, overrun_cnt, the shadow registers and the counters SHALL all be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously).
REQ-029 After reset release, the block SHALL ignore data until the first symbol_stb.

Configuration
REQ-030 With macro DSMUX_OVERRUN_CNT_EN defined, overrun_cnt SHALL increment on each overrun and saturate at 255.
REQ-031 Without DSMUX_OVERRUN_CNT_EN, overrun_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-032 Scenario: NUM_CH=4, mode=1, S=12, ds0=A5A5A5A5, strobe every 12 cycles -> out_data=A5A5A5A5 and out_valid=1 continuously, out_ch=0.
REQ-033 Scenario: mode=2, S=6, ds0=11111111, ds1=22222222, strobe every 12 cycles -> 6 cycles of 11111111 then 6 cycles of 22222222, with no gap.
REQ-034 Scenario: mode=3, S=4, strobe every 20 cycles -> 3 slots of 4 cycles, then out_valid=0 for 8 cycles, then a new frame.
REQ-035 Scenario: mode=4, S=5, strobe after 7 cycles -> frame restarts at lane 0, and overrun_cnt=1 (0 with the macro off).
REQ-036 Scenario: mode=7 with NUM_CH=4 -> 4 lanes driven and cfg_err=1; mode=0 -> out_valid stays 0.
REQ-037 Scenario: rst pulled low during slot 2 -> all outputs 0 immediately, and no output until the next symbol_stb.
